if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register.

---
 rtl/if_fetch_unit_if.sv | 12 +
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch channel: one outstanding word request at a time.
// The fetch unit drives req/addr as master; memory answers with ack/rdata
// in the cycle the word is valid.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues single-outstanding word fetches, buffers returned words
// in a small prefetch FIFO and presents the head entry to decode.
// Optional build macro IF_FETCH_PERF_EN adds saturating fetch/bubble counters.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no request outstanding; issues from pc when a slot will be free
// WAIT  | request outstanding, returned word will be pushed
// DROP  | request outstanding after a redirect, returned word discarded
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           IF_inst,
    output logic [31:0]           IF_pc4,
    output logic                  IF_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_bubble_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic [31:0]   addr_q, addr_nxt;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc4  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_after_pop;
    logic          push, pop, flush;
    logic [31:0]   redirect_target;
    logic [31:0]   addr_plus4;

    // Low two bits of the redirect target are dropped to keep fetches word aligned.
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign addr_plus4      = addr_q + 32'd4;

    assign flush           = redirect_valid;
    assign IF_valid        = (count != '0);
    assign IF_inst         = IF_valid ? fifo_inst[rd_ptr] : NOP_INST;
    assign IF_pc4          = IF_valid ? fifo_pc4[rd_ptr]  : 32'd0;
    assign pop             = IF_valid && !stall && !flush;
    assign push            = (state == S_WAIT) && imem.ack && !flush;
    assign count_after_pop = count - {{AW{1'b0}}, pop};

    assign imem.req        = (state != S_IDLE);
    assign imem.addr       = addr_q;

    // Next-state, PC and request address; redirect outranks everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        addr_nxt  = addr_q;
        case (state)
            S_IDLE: begin
                if (flush) begin
                    pc_nxt = redirect_target;
                end else if (count_after_pop < DEPTH_C) begin
                    addr_nxt  = pc;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_nxt    = redirect_target;
                    state_nxt = imem.ack ? S_IDLE : S_DROP;
                end else if (imem.ack) begin
                    pc_nxt    = addr_plus4;
                    state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (flush)
                    pc_nxt = redirect_target;
                // A same-cycle ack still closes the memory transaction.
                if (imem.ack)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM, PC and request-address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            addr_q <= addr_nxt;
        end
    end

    // FIFO pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem.rdata;
            fifo_pc4[wr_ptr]  <= addr_plus4;
        end
    end

`ifdef IF_FETCH_PERF_EN
    // Saturating counters: accepted pushes and un-stalled empty cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            if (push && (perf_fetch_cnt != 32'hFFFF_FFFF))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (!IF_valid && !stall && (perf_bubble_cnt != 32'hFFFF_FFFF))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, basic fetch, stall fill,
// redirect in WAIT, redirect with same-cycle ack, PC wrap, reset mid-request.
module tb_if_fetch_unit;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc4;
    logic        IF_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch_unit_if imem();

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .IF_inst        (IF_inst),
        .IF_pc4         (IF_pc4),
        .IF_valid       (IF_valid)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem.ack       = 1'b0;
        imem.rdata     = 32'd0;
        #1;
        chk("rst_req",   {31'd0, imem.req}, 32'd0);
        chk("rst_valid", {31'd0, IF_valid}, 32'd0);
        chk("rst_inst",  IF_inst, 32'h0);
        chk("rst_pc4",   IF_pc4,  32'h0);

        // T1: first fetch after release, ack one cycle later
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("t1_req",  {31'd0, imem.req}, 32'd1);
        chk("t1_addr", imem.addr, 32'h0);
        imem.ack = 1'b1; imem.rdata = 32'h2002_0001;
        step();
        imem.ack = 1'b0;
        chk("t1_valid", {31'd0, IF_valid}, 32'd1);
        chk("t1_inst",  IF_inst, 32'h2002_0001);
        chk("t1_pc4",   IF_pc4,  32'h4);
        step();
        chk("t1_req2",  {31'd0, imem.req}, 32'd1);
        chk("t1_addr2", imem.addr, 32'h4);
        chk("t1_popped", {31'd0, IF_valid}, 32'd0);

        // T2: stall held, immediate acks fill the FIFO then stop requesting
        stall = 1'b1;
        imem.ack = 1'b1; imem.rdata = 32'hA1A1_0001;
        step();
        imem.ack = 1'b0;
        chk("t2_head1", IF_inst, 32'hA1A1_0001);
        step();
        chk("t2_addr2", imem.addr, 32'h8);
        imem.ack = 1'b1; imem.rdata = 32'hA2A2_0002;
        step();
        imem.ack = 1'b0;
        step();
        chk("t2_full_noreq", {31'd0, imem.req}, 32'd0);
        step();
        step();
        chk("t2_full_noreq2", {31'd0, imem.req}, 32'd0);
        chk("t2_head_inst", IF_inst, 32'hA1A1_0001);
        chk("t2_head_pc4",  IF_pc4,  32'h8);
        stall = 1'b0;
        step();
        chk("t2_resume_req",  {31'd0, imem.req}, 32'd1);
        chk("t2_resume_addr", imem.addr, 32'hC);
        chk("t2_second_inst", IF_inst, 32'hA2A2_0002);
        chk("t2_second_pc4",  IF_pc4,  32'hC);
        step();
        chk("t2_drained", {31'd0, IF_valid}, 32'd0);

        // T3: redirect while WAIT, ack arrives 3 cycles later and is dropped
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("t3_req_held",  {31'd0, imem.req}, 32'd1);
        chk("t3_addr_held", imem.addr, 32'hC);
        step();
        step();
        imem.ack = 1'b1; imem.rdata = 32'hDEAD_DEAD;
        step();
        imem.ack = 1'b0;
        chk("t3_dropped", {31'd0, IF_valid}, 32'd0);
        chk("t3_idle",    {31'd0, imem.req}, 32'd0);
        step();
        chk("t3_new_addr", imem.addr, 32'h100);
        chk("t3_new_req",  {31'd0, imem.req}, 32'd1);

        // T4: redirect coincident with ack; low target bits ignored
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        imem.ack = 1'b1; imem.rdata = 32'hBEEF_BEEF;
        step();
        redirect_valid = 1'b0; imem.ack = 1'b0;
        chk("t4_not_pushed", {31'd0, IF_valid}, 32'd0);
        chk("t4_idle",       {31'd0, imem.req}, 32'd0);
        step();
        chk("t4_addr", imem.addr, 32'h200);

        // T5: PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        imem.ack = 1'b1; imem.rdata = 32'h1234_5678;
        step();
        imem.ack = 1'b0;
        chk("t5_drop_empty", {31'd0, IF_valid}, 32'd0);
        step();
        chk("t5_addr_top", imem.addr, 32'hFFFF_FFFC);
        imem.ack = 1'b1; imem.rdata = 32'h0000_0055;
        step();
        imem.ack = 1'b0;
        chk("t5_inst", IF_inst, 32'h0000_0055);
        chk("t5_pc4",  IF_pc4,  32'h0);
        step();
        chk("t5_wrap_addr", imem.addr, 32'h0);
        chk("t5_wrap_req",  {31'd0, imem.req}, 32'd1);

        // T6: asynchronous reset with an entry buffered and a request pending
        stall = 1'b1;
        imem.ack = 1'b1; imem.rdata = 32'h0000_0077;
        step();
        imem.ack = 1'b0;
        step();
        chk("t6_pre_valid", {31'd0, IF_valid}, 32'd1);
        chk("t6_pre_req",   {31'd0, imem.req}, 32'd1);
`ifdef IF_FETCH_PERF_EN
        chk("t6_perf_fetch_pre", perf_fetch_cnt, 32'd5);
`endif
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_req",   {31'd0, imem.req}, 32'd0);
        chk("t6_async_valid", {31'd0, IF_valid}, 32'd0);
        chk("t6_async_inst",  IF_inst, 32'h0);
        chk("t6_async_pc4",   IF_pc4,  32'h0);
`ifdef IF_FETCH_PERF_EN
        chk("t6_perf_fetch",  perf_fetch_cnt,  32'd0);
        chk("t6_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
        stall = 1'b0;
        imem.ack = 1'b1; imem.rdata = 32'h0000_0099;
        @(negedge clk);
        rst = 1'b1;
        step();
        imem.ack = 1'b0;
        chk("t6_late_ack_ignored", {31'd0, IF_valid}, 32'd0);
        chk("t6_restart_req",  {31'd0, imem.req}, 32'd1);
        chk("t6_restart_addr", imem.addr, 32'h0);
        imem.ack = 1'b1; imem.rdata = 32'h0000_0011;
        step();
        imem.ack = 1'b0;
        chk("t6_restart_inst", IF_inst, 32'h0000_0011);
        chk("t6_restart_pc4",  IF_pc4,  32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
